// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory wait timeout
//
// Sequences the multi-cycle MIPS datapath one instruction at a time.
// Inputs : clk, rst (sync, active-high), op/fn (instruction fields),
//          zero (ALU flag), mem_ready (memory access completes this cycle).
// Outputs: pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
//          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl (datapath
//          controls), illegal / bus_err (sticky status), state (debug).
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] fn,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctl,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    logic       rtype_ok;
    logic [2:0] rtype_alu;
    logic       mem_state;
    logic       timeout_hit;

    // R-type function decode; rtype_ok gates entry to RTYPE_EX.
    always_comb begin
        rtype_ok  = 1'b1;
        rtype_alu = ALU_ADD;
        case (fn)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_AND:  rtype_alu = ALU_AND;
            FN_OR:   rtype_alu = ALU_OR;
            FN_SLT:  rtype_alu = ALU_SLT;
            default: rtype_ok  = 1'b0;
        endcase
    end

    // The counter holds the number of wait cycles already spent in the
    // current memory state, so the cycle that would take it to TIMEOUT is
    // the timeout cycle. A mem_ready in that same cycle still completes.
    always_comb begin
        mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout_hit = (TIMEOUT != 4'd0) && !mem_ready && (wait_cnt_q == TIMEOUT - 4'd1);
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (rtype_ok) begin
                            state_d = S_RTYPE_EX;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = S_HALT;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            // Only lw and sw reach MEMADR, so op[3] alone separates them.
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase

        // Counter restarts on every state change, so each memory state
        // entry sees a fresh count.
        if (state_d != state_q) begin
            wait_cnt_d = 4'd0;
        end else if (mem_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Per-state datapath controls; everything is held low while rst is high
    // so an access interrupted by reset never sees a strobe in that cycle.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_ctl    = ALU_AND;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_ctl   = ALU_ADD;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        ir_write = 1'b1;
                        pc_src   = PCSRC_ALU;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM4;
                    alu_ctl   = ALU_ADD;
                end
                S_MEMADR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctl   = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_ctl   = rtype_alu;
                end
                S_RTYPE_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_ctl   = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = zero;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] fn = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic       illegal, bus_err;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctl;
    logic [3:0] state;
    logic [15:0] ctl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .op(op), .fn(fn), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
    //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl}
    assign ctl = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl};

    localparam logic [15:0] C_NONE  = 16'h0000;
    localparam logic [15:0] C_FWAIT = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010};
    localparam logic [15:0] C_FGO   = {1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010};
    localparam logic [15:0] C_DEC   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010};
    localparam logic [15:0] C_MADR  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010};
    localparam logic [15:0] C_MRD   = {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};
    localparam logic [15:0] C_MWB   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000};
    localparam logic [15:0] C_MWR   = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};
    localparam logic [15:0] C_RSLT  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111};
    localparam logic [15:0] C_RSUB  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110};
    localparam logic [15:0] C_ROR   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001};
    localparam logic [15:0] C_RWB   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000};
    localparam logic [15:0] C_BRZ   = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110};
    localparam logic [15:0] C_BRN   = {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110};
    localparam logic [15:0] C_AEX   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010};
    localparam logic [15:0] C_AWB   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};
    localparam logic [15:0] C_JMP   = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are already set; check state and controls mid-cycle, then
    // advance to just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] es, input logic [15:0] ec);
        #1;
        check_eq({tag, "_state"}, 32'(state), 32'(es));
        check_eq({tag, "_ctl"}, 32'(ctl), 32'(ec));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst_ctl"}, 32'(ctl), 32'(C_NONE));
        @(posedge clk);
        #2;
        check_eq({tag, "_rst_state"}, 32'(state), 32'd0);
        check_eq({tag, "_rst_illegal"}, 32'(illegal), 32'd0);
        check_eq({tag, "_rst_bus_err"}, 32'(bus_err), 32'd0);
        rst = 1'b0;
    endtask

    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        step({tag, "_fetch"}, 4'd0, C_FGO);
        step({tag, "_decode"}, 4'd1, C_DEC);
    endtask

    initial begin
        do_reset("init");

        // R-type SLT, SUB, OR
        op = 6'b000000; fn = 6'b101010;
        fetch_decode("slt");
        step("slt_ex", 4'd6, C_RSLT);
        step("slt_wb", 4'd7, C_RWB);
        fn = 6'b100010;
        fetch_decode("sub");
        step("sub_ex", 4'd6, C_RSUB);
        step("sub_wb", 4'd7, C_RWB);
        fn = 6'b100101;
        fetch_decode("or");
        step("or_ex", 4'd6, C_ROR);
        step("or_wb", 4'd7, C_RWB);

        // lw with 3 wait cycles in MEMRD: 8 cycles total
        op = 6'b100011;
        fetch_decode("lw");
        step("lw_adr", 4'd2, C_MADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_wait", 4'd3, C_MRD);
        mem_ready = 1'b1;
        step("lw_rd", 4'd3, C_MRD);
        step("lw_wb", 4'd4, C_MWB);

        // sw zero-wait
        op = 6'b101011;
        fetch_decode("sw");
        step("sw_adr", 4'd2, C_MADR);
        step("sw_wr", 4'd5, C_MWR);

        // beq taken / not taken
        op = 6'b000100; zero = 1'b1;
        fetch_decode("beq1");
        step("beq1_br", 4'd8, C_BRZ);
        zero = 1'b0;
        fetch_decode("beq0");
        step("beq0_br", 4'd8, C_BRN);

        // addi
        op = 6'b001000;
        fetch_decode("addi");
        step("addi_ex", 4'd9, C_AEX);
        step("addi_wb", 4'd10, C_AWB);

        // j
        op = 6'b000010;
        fetch_decode("j");
        step("j_jmp", 4'd11, C_JMP);
        step("j_back", 4'd0, C_FGO);
        step("j_dec", 4'd1, C_DEC);
        step("j_jmp2", 4'd11, C_JMP);

        // reset for 2 cycles in the middle of a MEMRD wait
        op = 6'b100011;
        fetch_decode("rlw");
        step("rlw_adr", 4'd2, C_MADR);
        mem_ready = 1'b0;
        step("rlw_wait", 4'd3, C_MRD);
        rst = 1'b1;
        step("rlw_rst0", 4'd3, C_NONE);
        step("rlw_rst1", 4'd0, C_NONE);
        rst = 1'b0;
        step("rlw_resume", 4'd0, C_FWAIT);

        // illegal opcode: HALT held for 20 cycles with all strobes low
        op = 6'b111111;
        fetch_decode("ill");
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'(i);
            step("ill_halt", 4'd12, C_NONE);
        end
        check_eq("ill_flag", 32'(illegal), 32'd1);
        check_eq("ill_no_bus_err", 32'(bus_err), 32'd0);
        do_reset("ill");

        // unsupported R-type function
        op = 6'b000000; fn = 6'b000000;
        fetch_decode("illfn");
        step("illfn_halt", 4'd12, C_NONE);
        check_eq("illfn_flag", 32'(illegal), 32'd1);
        do_reset("illfn");

        // fetch timeout after 15 wait cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step("to_wait", 4'd0, C_FWAIT);
        step("to_halt", 4'd12, C_NONE);
        check_eq("to_bus_err", 32'(bus_err), 32'd1);
        check_eq("to_illegal", 32'(illegal), 32'd0);
        do_reset("to");

        // mem_ready on the 15th cycle wins over the timeout
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) step("tw_wait", 4'd0, C_FWAIT);
        mem_ready = 1'b1;
        op = 6'b000010;
        step("tw_fetch", 4'd0, C_FGO);
        step("tw_decode", 4'd1, C_DEC);
        check_eq("tw_bus_err", 32'(bus_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the MIPS 32-bit datapath.
- Takes the op and fn fields from the instruction field decoder and the memory ready handshake.
- Drives per-cycle enables and selects for PC, IR, memory, register file and ALU.
- Sits between the instruction register/decoder and the datapath muxes; one instruction in flight.

Parameters:
- MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before raising bus_err (4-bit counter; 0 disables the timeout).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- op  input  6  opcode field (IC[31:26]).
- fn  input  6  function field (IC[5:0]).
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  load PC.
- pc_src  output  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target.
- ir_write  output  1  load IR.
- iord  output  1  memory address: 0 PC, 1 ALUOut.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  write-register select: 0 rt, 1 rd.
- mem_to_reg  output  1  write data: 0 ALUOut, 1 MDR.
- alu_src_a  output  1  ALU A: 0 PC, 1 rs data.
- alu_src_b  output  2  ALU B: 00 rt data, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- alu_ctl  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- illegal  output  1  sticky, unsupported op/fn detected.
- bus_err  output  1  sticky, memory timeout.
- state  output  4  current state encoding (debug).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: next edge with rst=1 gives state=FETCH(0) and clears illegal, bus_err and the wait counter. While rst=1, every control output is forced to 0.
- Decode is fixed for these encodings:
  - State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BRANCH 8, ADDI_EX 9, ADDI_WB 10, JUMP 11, HALT 12.
  - Supported ops: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
  - R-type fn: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Defaults: every output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctl=ADD.
  - pc_write=1, ir_write=1 and pc_src=00 are asserted only in the cycle mem_ready=1; that cycle goes to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=ADD (branch target into ALUOut).
  - lw/sw go to MEMADR; R-type goes to RTYPE_EX; beq to BRANCH; addi to ADDI_EX; j to JUMP.
  - Any other op, or R-type with an unsupported fn: set illegal and go to HALT.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: mem_read=1, iord=1. Goes to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_write=1, iord=1. Goes to FETCH on mem_ready.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_ctl from fn. Goes to RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, ADD. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_write=zero. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- HALT: all strobes 0. The block stays in HALT until rst.
- Memory wait (FETCH, MEMRD, MEMWR):
  - A 4-bit counter clears on entry to the state and increments each cycle with mem_ready=0.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: set bus_err and go to HALT.
  - mem_ready in the timeout cycle wins; the access completes normally.
- mem_ready outside the memory states is ignored.
- rst asserted in any state, including mid-wait, aborts the access at that edge; no strobe is asserted in the reset cycle.
- Latencies with zero-wait memory:
  - lw: 5 cycles.
  - sw and R-type: 4 cycles.
  - addi: 4 cycles.
  - beq and j: 3 cycles.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MEMRD -> state=0, all outputs 0 during rst, FETCH strobes resume the cycle after rst drops.
- R-type: op=000000, fn=101010, mem_ready=1 -> states 0,1,6,7,0. alu_ctl=111 in RTYPE_EX; reg_write=1, reg_dst=1 in RTYPE_WB.
- lw with 3 wait cycles in MEMRD: op=100011, mem_ready low for 3 cycles -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1. Total 8 cycles.
- beq both ways:
  - zero=1 -> pc_write=1, pc_src=01 in BRANCH.
  - zero=0 -> pc_write=0. Both return to FETCH.
- Illegal: op=111111 -> illegal=1 after DECODE, state=12, held for 20 cycles with all strobes 0.
- Timeout: MEM_TIMEOUT=15, mem_ready=0 in FETCH -> bus_err=1, HALT after 15 wait cycles.
  - Repeat with mem_ready=1 on the 15th cycle -> normal DECODE, bus_err=0.
